// File: rtl/serial_adder_ctrl.sv
// Bit-serial a+b+cin sequencer reusing one full-adder cell (two half adders) over WIDTH cycles.
// Latency WIDTH+1 cycles accept-to-done; start is ignored while busy, no other backpressure.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, part;
    logic             c;
    logic [CW-1:0]    bit_cnt;

    logic ha1_s, ha1_c, ha2_s, ha2_c, c_next, bit_s;
    logic accept, last;

    assign ha1_s  = a_sh[0] ^ b_sh[0];
    assign ha1_c  = a_sh[0] & b_sh[0];
    assign ha2_s  = ha1_s ^ c;
    assign ha2_c  = ha1_s & c;
    assign bit_s  = ha2_s;
    assign c_next = ha1_c | ha2_c;

    assign accept = (state == S_IDLE) && start;
    assign last   = (state == S_RUN) && (bit_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN) || (state == S_DONE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            part      <= '0;
            c         <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            part    <= '0;
            c       <= cin;
            bit_cnt <= '0;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            part <= {bit_s, part[WIDTH-1:1]};
            c    <= c_next;
            // Counter holds at WIDTH-1 on the exit edge so it never wraps.
            if (last) begin
                sum       <= {bit_s, part[WIDTH-1:1]};
                carry_out <= c_next;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule
